// File: rtl/wind_table_gen.sv
// Wind table writer: fills the wind RAM with LFSR-derived values in 0..WIND_MAX
// and reports a checksum so both boards can confirm that their tables match.
module wind_table_gen #(
  parameter int          DEPTH    = 128,
  parameter int          VAL_W    = 7,
  parameter int          WIND_MAX = 100,
  parameter logic [15:0] ALT_SEED = 16'hACE1,
  localparam int         AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [AW-1:0]    waddr,
  output logic [VAL_W-1:0] wdata,
  output logic [13:0]      checksum
);

  // state | meaning
  // IDLE  | waiting for the first start after reset
  // FILL  | stepping the LFSR one sample per cycle, writing accepted samples
  // DONE  | table complete, checksum valid, waiting for a new start
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_n;
  logic [AW-1:0]     addr;
  logic [13:0]       sum;
  logic [VAL_W-1:0]  smp;
  logic [13:0]       smp_ext;
  logic              accept;
  logic              last;

  always_comb begin
    lfsr_n  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    smp     = lfsr_n[VAL_W-1:0];
    smp_ext = {{(14-VAL_W){1'b0}}, smp};
    accept  = (32'(smp) <= WIND_MAX);
    last    = (addr == AW'(DEPTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= ALT_SEED;
      addr     <= '0;
      sum      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          we <= 1'b0;
          if (start) begin
            lfsr  <= (seed == 16'h0000) ? ALT_SEED : seed;
            addr  <= '0;
            sum   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= FILL;
          end
        end
        FILL: begin
          lfsr <= lfsr_n;
          we   <= accept;
          if (accept) begin
            waddr <= addr;
            wdata <= smp;
            addr  <= addr + 1'b1;
            sum   <= sum + smp_ext;
            // Final accept: done rises together with the last write pulse.
            if (last) begin
              busy     <= 1'b0;
              done     <= 1'b1;
              checksum <= sum + smp_ext;
              state    <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wind_table_gen.sv
// Directed bench for wind_table_gen: checks reset values, first-write latency,
// the write sequence against a reference LFSR, checksums, mid-fill start and reset.
module tb_wind_table_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic        busy, done, we;
  logic [6:0]  waddr;
  logic [6:0]  wdata;
  logic [13:0] checksum;

  int total = 0;
  int bad   = 0;

  int cur[128];
  int ref_a[128];
  int cks_a, cks_b, cks_c, first_cyc, mism;

  wind_table_gen dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .busy(busy), .done(done), .we(we), .waddr(waddr),
    .wdata(wdata), .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Runs one fill; each write is checked against a reference LFSR stepped
  // independently. abort_at >= 0 asserts rst when that address is written.
  task automatic do_fill(input logic [15:0] sd, input bit mid_start, input int abort_at,
                         output int cks, output int first_we);
    logic [15:0] m;
    logic [15:0] mn;
    int idx, sum, cyc;
    bit fin;
    m = (sd == 16'h0000) ? 16'hACE1 : sd;
    idx = 0; sum = 0; cyc = 0; fin = 0; first_we = -1; cks = -1;
    @(negedge clk); seed = sd; start = 1'b1;
    @(negedge clk); start = 1'b0; seed = 16'h5555; cyc = 1;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    while (!fin && cyc < 1000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (we) begin
        if (first_we < 0) first_we = cyc;
        do begin
          mn = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
          m  = mn;
        end while (mn[6:0] > 7'd100);
        chk("waddr_seq", waddr, idx);
        chk("wdata_model", wdata, mn[6:0]);
        if (idx < 128) cur[idx] = wdata;
        sum += wdata;
        idx++;
        if (mid_start && waddr == 7'd40) start = 1'b1;
        if (abort_at >= 0 && waddr == abort_at[6:0]) begin
          rst = 1'b1;
          fin = 1;
        end
      end
      if (!fin && done) begin
        chk("writes_at_done", idx, 128);
        chk("we_with_done", we, 1);
        chk("busy_at_done", busy, 0);
        chk("checksum_sum", checksum, sum);
        cks = checksum;
        fin = 1;
      end
    end
    if (!fin) chk("fill_timeout", cyc, 0);
  endtask

  initial begin
    int dummy;
    rst = 1'b1; start = 1'b0; seed = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_checksum", checksum, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_we", we, 0);

    // Seed 1: first samples are 0,0,0,0,64,32, first write 2 cycles after start.
    do_fill(16'h0001, 0, -1, cks_a, first_cyc);
    chk("first_we_latency", first_cyc, 2);
    chk("seed1_v0", cur[0], 0);
    chk("seed1_v1", cur[1], 0);
    chk("seed1_v2", cur[2], 0);
    chk("seed1_v3", cur[3], 0);
    chk("seed1_v4", cur[4], 64);
    chk("seed1_v5", cur[5], 32);
    @(negedge clk);
    chk("done_hold", done, 1);
    chk("we_low_in_done", we, 0);

    // Seed 0 uses the alternate seed.
    do_fill(16'h0000, 0, -1, cks_b, dummy);
    for (int i = 0; i < 128; i++) ref_a[i] = cur[i];
    do_fill(16'hACE1, 0, -1, cks_c, dummy);
    mism = 0;
    for (int i = 0; i < 128; i++) if (ref_a[i] != cur[i]) mism++;
    chk("seed0_vs_ace1_seq", mism, 0);
    chk("seed0_vs_ace1_cks", cks_b, cks_c);

    // Start mid-fill is ignored.
    do_fill(16'hACE1, 1, -1, cks_b, dummy);
    mism = 0;
    for (int i = 0; i < 128; i++) if (ref_a[i] != cur[i]) mism++;
    chk("midstart_seq", mism, 0);
    chk("midstart_cks", cks_b, cks_c);

    // Reset at waddr 60 aborts the fill.
    do_fill(16'h0001, 0, 60, dummy, dummy);
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_we", we, 0);
    chk("abort_checksum", checksum, 0);
    do_fill(16'h0001, 0, -1, cks_b, first_cyc);
    chk("refill_latency", first_cyc, 2);
    chk("refill_cks", cks_b, cks_a);

    // Restart from DONE with new seeds.
    do_fill(16'h1234, 0, -1, cks_b, dummy);
    do_fill(16'h1234, 0, -1, cks_c, dummy);
    chk("same_seed_cks", cks_c, cks_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
